// File: rtl/iq_decimator_pkg.sv
// Shared definitions for the receive-path mixer/decimator/capture chain.
// Carries the decimator FSM encoding and the default datapath widths so that
// the mixer output width and the decimator input width cannot drift apart.
package iq_decimator_pkg;

  // Mixer product width per channel (signed).
  localparam int IQ_IN_W  = 24;
  // Decimation counter width; largest ratio is 2**IQ_CNT_W - 1.
  localparam int IQ_CNT_W = 16;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } iq_state_e;

endpackage

// File: rtl/iq_decimator_if.sv
// Sample-in / frame-out bus of the I/Q integrate-and-dump decimator.
// Latency: n/a (wires only). Backpressure: input side has none; output side is valid/ready.
// Ports: in_valid/mixed_i/mixed_q (source -> decimator), out_valid/out_i/out_q (decimator -> sink), out_ready (sink -> decimator).
interface iq_decimator_if
  import iq_decimator_pkg::*;
#(
  parameter int IN_W  = IQ_IN_W,
  parameter int CNT_W = IQ_CNT_W
);
  localparam int ACC_W = IN_W + CNT_W;

  logic                    in_valid;
  logic signed [IN_W-1:0]  mixed_i;
  logic signed [IN_W-1:0]  mixed_q;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [ACC_W-1:0] out_i;
  logic signed [ACC_W-1:0] out_q;

  // master: the side feeding samples and consuming frames.
  modport master (
    output in_valid, mixed_i, mixed_q, out_ready,
    input  out_valid, out_i, out_q
  );

  // slave: the decimator itself.
  modport slave (
    input  in_valid, mixed_i, mixed_q, out_ready,
    output out_valid, out_i, out_q
  );

endinterface

// File: rtl/iq_accum.sv
// One channel of the integrate-and-dump: signed accumulator with clear and dump.
// Latency: result is combinational (acc + sample); the accumulator updates on the clock edge.
// Backpressure: none; the caller decides when a sample is taken (en) and when it ends a frame (dump).
// Ports: clk/rst, clr (force acc to 0), en (take sample), dump (sample closes the frame), sample in, result out.
module iq_accum
  import iq_decimator_pkg::*;
#(
  parameter int IN_W  = IQ_IN_W,
  parameter int ACC_W = IQ_IN_W + IQ_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    en,
  input  logic                    dump,
  input  logic signed [IN_W-1:0]  sample,
  output logic signed [ACC_W-1:0] result
);

  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] sample_ext;

  assign sample_ext = {{(ACC_W-IN_W){sample[IN_W-1]}}, sample};
  // Frame total including the current sample; valid as the dump value when dump is high.
  assign result     = acc_q + sample_ext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else if (clr) begin
      acc_q <= '0;
    end else if (en) begin
      acc_q <= dump ? '0 : result;
    end
  end

endmodule

// File: rtl/iq_decimator.sv
// Integrate-and-dump I/Q decimator: sums decim_ratio samples per channel and emits one full-precision pair per frame.
// Latency: out_valid rises on the same edge that samples the frame's final in_valid (visible the next cycle).
// Backpressure: inputs are never stalled; a frame completing while the output is still pending is dropped and flags overrun.
// Ports: clk, rst (async, active-high), enable, decim_ratio, bus (iq_decimator_if.slave), busy, overrun.
module iq_decimator
  import iq_decimator_pkg::*;
#(
  parameter int IN_W  = IQ_IN_W,
  parameter int CNT_W = IQ_CNT_W,
  parameter int ACC_W = IN_W + CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [CNT_W-1:0] decim_ratio,
  iq_decimator_if.slave    bus,
  output logic             busy,
  output logic             overrun
);

  iq_state_e               state_q;
  logic [CNT_W-1:0]        ratio_q;
  logic [CNT_W-1:0]        count_q;
  logic                    out_valid_q;
  logic signed [ACC_W-1:0] out_i_q;
  logic signed [ACC_W-1:0] out_q_q;
  logic                    overrun_q;

  logic                    accept;
  logic                    dump;
  logic                    acc_clr;
  logic signed [ACC_W-1:0] res_i;
  logic signed [ACC_W-1:0] res_q;

  // Samples are only taken in RUN, including the cycle in which enable falls,
  // so a frame finishing on that cycle is still delivered.
  assign accept  = (state_q == ST_RUN) && bus.in_valid;
  assign dump    = accept && (count_q == ratio_q - CNT_W'(1));
  // Accumulators are held at zero in IDLE and wiped when leaving RUN, so a
  // partial frame never leaks into the next run.
  assign acc_clr = (state_q == ST_IDLE) || !enable;

  iq_accum #(.IN_W(IN_W), .ACC_W(ACC_W)) u_acc_i (
    .clk    (clk),
    .rst    (rst),
    .clr    (acc_clr),
    .en     (accept),
    .dump   (dump),
    .sample (bus.mixed_i),
    .result (res_i)
  );

  iq_accum #(.IN_W(IN_W), .ACC_W(ACC_W)) u_acc_q (
    .clk    (clk),
    .rst    (rst),
    .clr    (acc_clr),
    .en     (accept),
    .dump   (dump),
    .sample (bus.mixed_q),
    .result (res_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ratio_q     <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_i_q     <= '0;
      out_q_q     <= '0;
      overrun_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (enable) begin
            state_q <= ST_RUN;
            // Ratios 0 and 1 both mean pass-through.
            ratio_q <= (decim_ratio < CNT_W'(2)) ? CNT_W'(1) : decim_ratio;
            count_q <= '0;
          end
        end
        ST_RUN: begin
          if (!enable) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            overrun_q <= 1'b0;
          end else if (accept) begin
            count_q <= dump ? '0 : count_q + CNT_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      // Output register: a fresh frame may replace one consumed this same cycle;
      // otherwise the older result wins and the new one is lost. A drop on the
      // cycle enable falls is still reported (assigned after the clear above).
      if (dump) begin
        if (!out_valid_q || bus.out_ready) begin
          out_valid_q <= 1'b1;
          out_i_q     <= res_i;
          out_q_q     <= res_q;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_i     = out_i_q;
  assign bus.out_q     = out_q_q;
  assign busy          = (state_q == ST_RUN);
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_iq_decimator.sv
// Randomised scoreboard bench for iq_decimator: a frame-level reference model
// pushes expected sums into queues, and a negedge monitor pops and compares on
// every output handshake while also tracking out_valid, busy and overrun.
module tb_iq_decimator;
  import iq_decimator_pkg::*;

  localparam int IN_W  = IQ_IN_W;
  localparam int CNT_W = IQ_CNT_W;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             enable = 1'b0;
  logic [CNT_W-1:0] decim_ratio = '0;
  logic             busy;
  logic             overrun;

  iq_decimator_if #(.IN_W(IN_W), .CNT_W(CNT_W)) bus ();

  iq_decimator dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .decim_ratio (decim_ratio),
    .bus         (bus),
    .busy        (busy),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  task automatic check(input string name, input longint act, input longint exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // ---------------- reference model (frame level) ----------------
  bit     m_run  = 0;
  bit     m_pend = 0;
  bit     m_ovr  = 0;
  int     m_ratio = 1;
  longint fr_i[$];
  longint fr_q[$];
  longint eq_i[$];
  longint eq_q[$];

  // Current stimulus, as seen by the DUT at the next edge.
  bit en_d = 0, vld_d = 0, rdy_d = 0;
  int di_d = 0, dq_d = 0;

  function automatic longint qsum(input longint q[$]);
    longint s = 0;
    foreach (q[k]) s += q[k];
    return s;
  endfunction

  task automatic model_edge();
    bit     dmp = 0;
    longint si = 0, sq = 0;
    bit     consume = m_pend && rdy_d;
    if (!m_run) begin
      if (en_d) begin
        m_run   = 1;
        m_ratio = (decim_ratio < 2) ? 1 : int'(decim_ratio);
        fr_i.delete(); fr_q.delete();
      end
    end else begin
      if (vld_d) begin
        fr_i.push_back(longint'(di_d));
        fr_q.push_back(longint'(dq_d));
        if (fr_i.size() == m_ratio) begin
          dmp = 1;
          si  = qsum(fr_i);
          sq  = qsum(fr_q);
          fr_i.delete(); fr_q.delete();
        end
      end
      if (!en_d) begin
        m_run = 0;
        m_ovr = 0;
        fr_i.delete(); fr_q.delete();
      end
    end
    if (dmp) begin
      if (!m_pend || rdy_d) begin
        eq_i.push_back(si);
        eq_q.push_back(sq);
        m_pend = 1;
      end else begin
        m_ovr = 1;
      end
    end else if (consume) begin
      m_pend = 0;
    end
  endtask

  // Drive one cycle of stimulus (called at posedge+1), advance to posedge+1.
  task automatic step(input bit e, input bit v, input int i, input int q, input bit r);
    en_d = e; vld_d = v; di_d = i; dq_d = q; rdy_d = r;
    enable        = e;
    bus.in_valid  = v;
    bus.mixed_i   = i[IN_W-1:0];
    bus.mixed_q   = q[IN_W-1:0];
    bus.out_ready = r;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  function automatic int rnd_s();
    return int'($urandom_range(0, (1 << IN_W) - 1)) - (1 << (IN_W - 1));
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      check("out_valid", longint'(bus.out_valid), longint'(m_pend));
      check("busy", longint'(busy), longint'(m_run));
      check("overrun", longint'(overrun), longint'(m_ovr));
      if (bus.out_valid && bus.out_ready) begin
        if (eq_i.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          check("out_i", bus.out_i, eq_i.pop_front());
          check("out_q", bus.out_q, eq_q.pop_front());
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.in_valid  = 1'b0;
    bus.mixed_i   = '0;
    bus.mixed_q   = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", longint'(bus.out_valid), 0);
    check("rst_out_i", bus.out_i, 0);
    check("rst_out_q", bus.out_q, 0);
    check("rst_busy", longint'(busy), 0);
    check("rst_overrun", longint'(overrun), 0);
    rst = 1'b0;

    // Ratio 4, constant inputs; the enable cycle's sample must be ignored.
    decim_ratio = 16'd4;
    step(1, 1, 1000, -250, 1);
    for (int k = 0; k < 12; k++) begin
      step(1, 1, 1000, -250, 1);
      if (k == 3) begin
        check("r4_latency_valid", longint'(bus.out_valid), 1);
        check("r4_out_i", bus.out_i, 4000);
        check("r4_out_q", bus.out_q, -1000);
      end
    end
    step(1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);

    // Pass-through with ratio 0.
    decim_ratio = 16'd0;
    step(1, 0, 0, 0, 1);
    for (int k = 0; k < 20; k++) step(1, 1, rnd_s(), rnd_s(), 1);
    step(1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);

    // Overrun: ratio 2, consumer stalled for 6 samples.
    decim_ratio = 16'd2;
    step(1, 0, 0, 0, 0);
    for (int k = 0; k < 6; k++) step(1, 1, 100 + k, -k, 0);
    check("ovr_set", longint'(overrun), 1);
    check("ovr_held_i", bus.out_i, 201);
    step(1, 0, 0, 0, 1);
    check("ovr_consumed", longint'(bus.out_valid), 0);
    check("ovr_still_set", longint'(overrun), 1);
    step(0, 0, 0, 0, 1);
    check("ovr_cleared", longint'(overrun), 0);

    // Partial frame discarded on enable drop, then a clean ratio-8 run.
    decim_ratio = 16'd8;
    step(1, 0, 0, 0, 1);
    for (int k = 0; k < 3; k++) step(1, 1, 5000, 7000, 1);
    step(0, 0, 0, 0, 1);
    step(1, 1, 9999, 9999, 1);
    for (int k = 0; k < 8; k++) step(1, 1, k + 1, -(k + 1), 1);
    check("r8_out_i", bus.out_i, 36);
    check("r8_out_q", bus.out_q, -36);
    step(1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);

    // Randomised rounds: random ratio, sparse input, random backpressure.
    for (int r = 0; r < 3; r++) begin
      decim_ratio = CNT_W'($urandom_range(0, 5));
      step(1, 0, 0, 0, 1);
      for (int k = 0; k < 300; k++)
        step(1, $urandom_range(0, 3) != 0, rnd_s(), rnd_s(), 1'($urandom_range(0, 1)));
      repeat (3) step(1, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1);
    end

    // Full-scale negative input at the maximum ratio: must not wrap.
    decim_ratio = 16'hFFFF;
    step(1, 0, 0, 0, 1);
    for (int k = 0; k < 65535; k++) step(1, 1, -8388608, rnd_s(), 1);
    check("max_ratio_out_i", bus.out_i, -64'sd549747425280);
    step(1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);

    // Asynchronous reset mid-frame with a result pending.
    decim_ratio = 16'd2;
    step(1, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) step(1, 1, 123, -456, 0);
    check("pre_rst_valid", longint'(bus.out_valid), 1);
    rst = 1'b1;
    #1;
    check("rst_mid_valid", longint'(bus.out_valid), 0);
    check("rst_mid_out_i", bus.out_i, 0);
    check("rst_mid_out_q", bus.out_q, 0);
    check("rst_mid_busy", longint'(busy), 0);
    m_run = 0; m_pend = 0; m_ovr = 0;
    fr_i.delete(); fr_q.delete(); eq_i.delete(); eq_q.delete();
    enable = 1'b0; en_d = 0;
    bus.in_valid = 1'b0; vld_d = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) step(0, 0, 0, 0, 1);

    check("drain_empty", longint'(eq_i.size()), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/iq_decimator.md
# iq_decimator

Integrate-and-dump decimator for the receive path, directly downstream of the quadrature mixer. Accepts the mixer's 24-bit signed I and Q products at the sample rate, sums DECIM consecutive samples per channel, and emits one full-precision I/Q pair per frame over a valid/ready handshake. It provides the first low-pass and rate reduction ahead of the capture FIFO and readout logic.

## Interface
- IN_W, 24, signed input width per channel; matches the mixer output width
- CNT_W, 16, decimation counter width; maximum ratio 2^CNT_W − 1
- ACC_W, IN_W+CNT_W (40), accumulator and output width per channel
- clk  in  1  system clock; all logic on the rising edge
- rst  in  1  asynchronous, active-high reset
- enable  in  1  run control; high = accumulate, low = idle
- decim_ratio  in  CNT_W  samples per output frame; sampled on the IDLE→RUN transition only
- in_valid  in  1  mixed_i and mixed_q are valid this cycle; no input backpressure
- mixed_i  in  IN_W  signed I product from the mixer
- mixed_q  in  IN_W  signed Q product from the mixer
- out_valid  out  1  out_i and out_q hold an unconsumed result
- out_ready  in  1  consumer accepts the result when out_valid && out_ready
- out_i  out  ACC_W  signed I frame sum
- out_q  out  ACC_W  signed Q frame sum
- busy  out  1  high in RUN
- overrun  out  1  sticky: a completed frame was dropped

## Operation
- FSM states: IDLE, RUN.
- IDLE→RUN on enable=1: latch decim_ratio into ratio_q (0 or 1 → 1, pass-through); clear both accumulators and the sample counter.
- RUN→IDLE on enable=0: discard the partial frame; clear the accumulators and counter. The pending output register is kept until consumed. overrun clears on this transition.
- in_valid is ignored in IDLE.
- Arithmetic: sign-extend inputs to ACC_W; two's-complement addition. No rounding or truncation. ACC_W guarantees no wrap for any legal ratio.
- Per accepted sample in RUN:
  - If count < ratio_q−1: acc += sample; count++.
  - If count == ratio_q−1 (dump): result = acc + sample; acc ← 0; count ← 0.
- Dump to the output register:
  - out_valid=0, or out_ready=1 in the same cycle: load result; out_valid ← 1.
  - Otherwise: keep the pending result, drop the new one, set overrun.
- Consumption: out_valid && out_ready with no dump in that cycle → out_valid ← 0.
- The I and Q channels share the counter and are always dumped together.

## Timing
- Reset values: out_valid=0, out_i=0, out_q=0, busy=0, overrun=0. State IDLE; accumulators and counter 0.
- Latency: out_valid rises one cycle after the clk edge that samples the frame's final in_valid.
- Throughput: one input per cycle; with ratio 1, one output per cycle when out_ready is held high.
- The first accepted sample is at the earliest the cycle after the IDLE→RUN edge. Samples presented in the cycle enable rises are ignored.
- enable=0 and a dump in the same cycle: the dump completes and loads the output, then the block enters IDLE.
- rst mid-frame: all state clears immediately, including any pending output.

## Structure
- Shared package: the FSM state encoding (IDLE, RUN) and the default IN_W and CNT_W values, shared with the mixer and the capture FIFO.
- Sub-module iq_accum: one signed ACC_W accumulator with a clear/dump input, instantiated once each for I and Q. The counter, FSM, and output register stay at top level.

## Test plan
- ratio 4, constant mixed_i=1000, mixed_q=−250, out_ready=1 → out_i=4000, out_q=−1000, one out_valid pulse every 4 input samples, 1-cycle latency.
- ratio 65535, mixed_i=−8388608 every cycle → out_i=−549747425280 with no wrap; out_q tracks its own input.
- ratio 0 → pass-through: each input appears sign-extended on the next cycle.
- ratio 2, out_ready=0 for 6 samples → first result held, overrun=1, later frames dropped. Raise out_ready → first result consumed. Toggle enable → overrun clears.
- enable dropped after 3 of 8 samples, then re-enabled with ratio 8 → the first output sums only the 8 new samples; the partial frame is never emitted.
- rst asserted mid-frame with an output pending → out_valid=0, outputs 0, busy=0 immediately.
